pool_ctrl: RTL and testbench

Sequencer for the 3x3 max-pooling datapath (3-cycle pipelined, 16-bit signed, 9 window inputs plus valid_in; max_out/valid_out). It walks a feature map held in a single-port sync-read input buffer and assembles each 3x3 window. It issues one pooling op per window and writes each pooled result to an output buffer in raster order. It sits between the layer scheduler (start/done) and the pooling unit plus its buffers.

---
 rtl/pool_ctrl_if.sv | 41 ++++
 rtl/pool_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pool_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pool_ctrl_if : scheduler, buffer and pooling-unit signals of pool_ctrl |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface pool_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int DIM_W  = 6,
  parameter int ADDR_W = 12
);
  logic                  start;
  logic [DIM_W-1:0]      cfg_width;
  logic [DIM_W-1:0]      cfg_height;
  logic                  cfg_stride2;
  logic                  busy;
  logic                  done;
  logic                  cfg_err;
  logic                  in_rd_en;
  logic [ADDR_W-1:0]     in_rd_addr;
  logic [DATA_W-1:0]     in_rd_data;
  logic                  pool_valid_in;
  logic [9*DATA_W-1:0]   pool_win;
  logic [DATA_W-1:0]     pool_max;
  logic                  pool_valid;
  logic                  out_wr_en;
  logic [ADDR_W-1:0]     out_wr_addr;
  logic [DATA_W-1:0]     out_wr_data;

  modport master (
    input  start, cfg_width, cfg_height, cfg_stride2, in_rd_data, pool_max, pool_valid,
    output busy, done, cfg_err, in_rd_en, in_rd_addr, pool_valid_in, pool_win,
           out_wr_en, out_wr_addr, out_wr_data
  );

  modport slave (
    output start, cfg_width, cfg_height, cfg_stride2, in_rd_data, pool_max, pool_valid,
    input  busy, done, cfg_err, in_rd_en, in_rd_addr, pool_valid_in, pool_win,
           out_wr_en, out_wr_addr, out_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/pool_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pool_ctrl : 3x3 max-pool sequencer (fetch window, issue, write back) |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module pool_ctrl #(
  parameter int DATA_W = 16,
  parameter int DIM_W  = 6,
  parameter int ADDR_W = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  pool_ctrl_if.master   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            state;
  logic [DIM_W-1:0]      width;
  logic [DIM_W-1:0]      height;
  logic                  stride2;
  logic [DIM_W-1:0]      ox;
  logic [DIM_W-1:0]      oy;
  logic [1:0]            dx;
  logic [1:0]            dy;
  logic [3:0]            k;
  logic                  rd_pend;
  logic [3:0]            cap_k;
  logic [DATA_W-1:0]     slot [0:7];
  logic [9*DATA_W-1:0]   win;
  logic [ADDR_W-1:0]     wr_cnt;
  logic                  err;

  logic [DIM_W:0]        step;
  logic [DIM_W:0]        ox_next;
  logic [DIM_W:0]        oy_next;
  logic [DIM_W:0]        ox_lim;
  logic [DIM_W:0]        oy_lim;
  logic                  wrap;
  logic                  last_win;
  logic [DIM_W-1:0]      out_w;
  logic [DIM_W-1:0]      out_h;
  logic [2*DIM_W-1:0]    prod;
  logic [ADDR_W-1:0]     total;
  logic [DIM_W:0]        row;
  logic [DIM_W:0]        col;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  bad_cfg;
  logic                  wr_fire;
  logic                  fetching;

  assign step     = stride2 ? (DIM_W+1)'(2) : (DIM_W+1)'(1);
  assign ox_next  = {1'b0, ox} + step;
  assign oy_next  = {1'b0, oy} + step;
  assign ox_lim   = {1'b0, width} - (DIM_W+1)'(3);
  assign oy_lim   = {1'b0, height} - (DIM_W+1)'(3);
  assign wrap     = ox_next > ox_lim;
  assign last_win = wrap && (oy_next > oy_lim);

  // Window count only matters once a legal (>=3) config is latched.
  assign out_w = ((width  - DIM_W'(3)) >> stride2) + DIM_W'(1);
  assign out_h = ((height - DIM_W'(3)) >> stride2) + DIM_W'(1);
  assign prod  = {{DIM_W{1'b0}}, out_w} * {{DIM_W{1'b0}}, out_h};
  assign total = ADDR_W'(prod);

  assign row     = {1'b0, oy} + {{(DIM_W-1){1'b0}}, dy};
  assign col     = {1'b0, ox} + {{(DIM_W-1){1'b0}}, dx};
  assign rd_addr = ADDR_W'(row) * ADDR_W'(width) + ADDR_W'(col);

  assign bad_cfg  = (bus.cfg_width < DIM_W'(3)) || (bus.cfg_height < DIM_W'(3));
  assign fetching = (state == S_FETCH);
  assign wr_fire  = bus.pool_valid && (state != S_IDLE);

  assign bus.busy          = (state != S_IDLE) && (state != S_DONE);
  assign bus.done          = (state == S_DONE);
  assign bus.cfg_err       = err;
  assign bus.in_rd_en      = fetching;
  assign bus.in_rd_addr    = fetching ? rd_addr : '0;
  assign bus.pool_valid_in = (state == S_ISSUE);
  assign bus.pool_win      = win;
  assign bus.out_wr_en     = wr_fire;
  assign bus.out_wr_addr   = wr_cnt;
  assign bus.out_wr_data   = bus.pool_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      width   <= '0;
      height  <= '0;
      stride2 <= 1'b0;
      ox      <= '0;
      oy      <= '0;
      dx      <= '0;
      dy      <= '0;
      k       <= '0;
      rd_pend <= 1'b0;
      cap_k   <= '0;
      win     <= '0;
      wr_cnt  <= '0;
      err     <= 1'b0;
      for (int i = 0; i < 8; i++) slot[i] <= '0;
    end else begin
      rd_pend <= fetching;
      cap_k   <= k;
      // Slot 8 is never stored; it is forwarded straight into the window in WAIT.
      if (rd_pend && !cap_k[3]) slot[cap_k[2:0]] <= bus.in_rd_data;
      if (wr_fire) wr_cnt <= wr_cnt + ADDR_W'(1);

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            width   <= bus.cfg_width;
            height  <= bus.cfg_height;
            stride2 <= bus.cfg_stride2;
            err     <= bad_cfg;
            wr_cnt  <= '0;
            ox      <= '0;
            oy      <= '0;
            dx      <= '0;
            dy      <= '0;
            k       <= '0;
            state   <= bad_cfg ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (dx == 2'd2) begin
            dx <= '0;
            dy <= dy + 2'd1;
          end else begin
            dx <= dx + 2'd1;
          end
          k <= k + 4'd1;
          if (k == 4'd8) begin
            k     <= '0;
            dx    <= '0;
            dy    <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          for (int i = 0; i < 8; i++) win[i*DATA_W +: DATA_W] <= slot[i];
          win[8*DATA_W +: DATA_W] <= bus.in_rd_data;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (wrap) begin
            ox <= '0;
            oy <= oy_next[DIM_W-1:0];
          end else begin
            ox <= ox_next[DIM_W-1:0];
          end
          state <= last_win ? S_DRAIN : S_FETCH;
        end
        S_DRAIN: begin
          // Count the write landing this cycle so done follows the last write directly.
          if ((wr_cnt == total) || (wr_fire && (wr_cnt + ADDR_W'(1) == total)))
            state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pool_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pool_ctrl : scoreboard bench with buffer and pooling-unit models  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_pool_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pool_ctrl_if #(.DATA_W(16), .DIM_W(6), .ADDR_W(12)) bus ();
  pool_ctrl #(.DATA_W(16), .DIM_W(6), .ADDR_W(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {int addr; int data; int off;} wr_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_wr_cyc = 0;
  int done_cnt = 0;
  int wr_cnt_layer = 0;
  bit exp_err = 1'b0;
  int rdq[$];
  wr_t wrq[$];

  logic signed [15:0] mem [0:4095];
  logic [15:0] outmem [0:4095];

  logic [15:0] m1, m2, m3;
  logic v1, v2, v3;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.in_rd_en) bus.in_rd_data <= mem[bus.in_rd_addr];
  always @(posedge clk) if (bus.out_wr_en) outmem[bus.out_wr_addr] <= bus.out_wr_data;

  function automatic logic [15:0] max9(input logic [143:0] w);
    logic signed [15:0] m;
    m = w[15:0];
    for (int i = 1; i < 9; i++) if ($signed(w[i*16 +: 16]) > m) m = w[i*16 +: 16];
    return m;
  endfunction

  // Three-stage pooling unit sharing rst_n with the controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1, v2, v3} <= 3'b000;
      m1 <= '0; m2 <= '0; m3 <= '0;
    end else begin
      v1 <= bus.pool_valid_in; v2 <= v1; v3 <= v2;
      m1 <= max9(bus.pool_win); m2 <= m1; m3 <= m2;
    end
  end
  assign bus.pool_valid = v3;
  assign bus.pool_max   = m3;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc - start_cyc);
    end
  endtask

  // Reference: enumerate windows by stride, max over mem, timing 14 + 11*n.
  task automatic expect_layer(input int w, input int h, input bit s2);
    int s;
    int n;
    int mx;
    int a;
    s = s2 ? 2 : 1;
    n = 0;
    rdq.delete();
    wrq.delete();
    exp_err = (w < 3) || (h < 3);
    if (!exp_err) begin
      for (int oy = 0; oy + 3 <= h; oy += s) begin
        for (int ox = 0; ox + 3 <= w; ox += s) begin
          mx = -40000;
          for (int kk = 0; kk < 9; kk++) begin
            a = (oy + kk / 3) * w + ox + kk % 3;
            rdq.push_back(a);
            if (int'(mem[a]) > mx) mx = int'(mem[a]);
          end
          wrq.push_back('{n, mx, 14 + 11 * n});
          n++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (bus.in_rd_en) begin
        chk("read_expected", rdq.size() != 0, 1);
        if (rdq.size() != 0) chk("rd_addr", bus.in_rd_addr, rdq.pop_front());
      end
      if (bus.out_wr_en) begin
        chk("write_expected", wrq.size() != 0, 1);
        if (wrq.size() != 0) begin
          e = wrq.pop_front();
          chk("wr_addr", bus.out_wr_addr, e.addr);
          chk("wr_data", int'($signed(bus.out_wr_data)), e.data);
          chk("wr_cycle", cyc - start_cyc, e.off);
        end
        last_wr_cyc = cyc;
        wr_cnt_layer++;
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_cycle", cyc - start_cyc, exp_err ? 1 : last_wr_cyc - start_cyc + 1);
        chk("pending_at_done", rdq.size() + wrq.size(), 0);
        chk("busy_at_done", bus.busy, 0);
      end
    end
  end

  task automatic run_start(input int w, input int h, input bit s2);
    @(negedge clk);
    expect_layer(w, h, s2);
    start_cyc = cyc;
    wr_cnt_layer = 0;
    bus.start = 1'b1;
    bus.cfg_width = 6'(w);
    bus.cfg_height = 6'(h);
    bus.cfg_stride2 = s2;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int t;
    d0 = done_cnt;
    t = 0;
    while (done_cnt == d0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done_cnt != d0, 1);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rd_en"}, bus.in_rd_en, 0);
    chk({tag, "_valid_in"}, bus.pool_valid_in, 0);
    chk({tag, "_wr_en"}, bus.out_wr_en, 0);
    chk({tag, "_win_zero"}, bus.pool_win == '0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int t;
    bus.start = 1'b0;
    bus.cfg_width = '0;
    bus.cfg_height = '0;
    bus.cfg_stride2 = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 4096; i++) begin mem[i] = 16'(i); outmem[i] = '0; end
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_cfg_err", bus.cfg_err, 0);
    rst_n = 1'b1;

    // 4x4 stride 1, pixel = address
    run_start(4, 4, 1'b0);
    chk("busy_cycle1", bus.busy, 1);
    wait_done(200);
    chk("m4_o0", outmem[0], 10); chk("m4_o1", outmem[1], 11);
    chk("m4_o2", outmem[2], 14); chk("m4_o3", outmem[3], 15);
    chk("busy_after_done", bus.busy, 0);

    // 5x5 stride 2
    run_start(5, 5, 1'b1);
    wait_done(200);
    chk("m5_o0", outmem[0], 12); chk("m5_o1", outmem[1], 14);
    chk("m5_o2", outmem[2], 22); chk("m5_o3", outmem[3], 24);

    // 3x3 negative, then all-min pixels
    for (int i = 0; i < 9; i++) mem[i] = 16'(-100 - i);
    run_start(3, 3, 1'b0);
    wait_done(100);
    chk("neg_max", outmem[0], 16'hFF9C);
    for (int i = 0; i < 9; i++) mem[i] = 16'h8000;
    run_start(3, 3, 1'b0);
    wait_done(100);
    chk("min_pix", outmem[0], 16'h8000);

    // illegal config
    run_start(2, 5, 1'b0);
    wait_done(20);
    chk("cfg_err_set", bus.cfg_err, 1);
    chk("err_writes", wr_cnt_layer, 0);

    // start while busy is ignored; valid start clears cfg_err
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
    run_start(4, 4, 1'b0);
    chk("cfg_err_cleared", bus.cfg_err, 0);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.cfg_width = 6'd5; bus.cfg_height = 6'd5; bus.cfg_stride2 = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(200);
    repeat (30) @(negedge clk);
    chk("busy_start_writes", wr_cnt_layer, 4);
    chk("busy_start_dones", done_cnt - d0, 1);

    // reset during fetch of window 2
    run_start(4, 4, 1'b0);
    t = 0;
    while (cyc - start_cyc < 13 && t < 50) begin @(negedge clk); t++; end
    chk("reach_window2", cyc - start_cyc, 13);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    repeat (2) @(negedge clk);
    rdq.delete();
    wrq.delete();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_done_on_reset", done_cnt - d0, 0);
    for (int i = 0; i < 4; i++) outmem[i] = '0;
    run_start(4, 4, 1'b0);
    wait_done(200);
    chk("rerun_writes", wr_cnt_layer, 4);
    chk("rerun_o0", outmem[0], 10);
    chk("rerun_o3", outmem[3], 15);

    // random layers
    for (int it = 0; it < 8; it++) begin
      int w;
      int h;
      bit s2;
      w = int'($urandom_range(3, 12));
      h = int'($urandom_range(3, 12));
      s2 = 1'($urandom_range(0, 1));
      for (int i = 0; i < w * h; i++)
        mem[i] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      run_start(w, h, s2);
      wait_done(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
